// File: rtl/uart_cmd_parser_if.sv
// Handshake bundle for uart_cmd_parser.
// The slave modport is the parser side. The master modport is the side that
// drives received bytes and consumes command words.
//   i_rx_data/i_rx_valid : received byte and its single-cycle strobe
//   o_cmd/o_cmd_valid    : assembled command word and its valid flag
//   i_cmd_ready          : the consumer accepts o_cmd while o_cmd_valid is high
//   o_err/o_overrun      : single-cycle pulses reporting a syntax error or a dropped byte
interface uart_cmd_parser_if #(
  parameter int unsigned cmd_width = 8
);
  logic [7:0]           i_rx_data;
  logic                 i_rx_valid;
  logic [cmd_width-1:0] o_cmd;
  logic                 o_cmd_valid;
  logic                 i_cmd_ready;
  logic                 o_err;
  logic                 o_overrun;

  modport slave (
    input  i_rx_data, i_rx_valid, i_cmd_ready,
    output o_cmd, o_cmd_valid, o_err, o_overrun
  );

  modport master (
    output i_rx_data, i_rx_valid, i_cmd_ready,
    input  o_cmd, o_cmd_valid, o_err, o_overrun
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Assembles lines of ASCII hex digits from the UART receive byte stream into
// cmd_width-bit command words. Each word is offered on a valid/ready handshake.
// Malformed lines are dropped and reported on o_err. Bytes that arrive while a
// word is pending are dropped and reported on o_overrun.
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset
//   bus : uart_cmd_parser_if.slave (rx byte in, command out, err/overrun pulses)
module uart_cmd_parser #(
  parameter int unsigned cmd_width = 8
) (
  input logic              clk,
  input logic              rst,
  uart_cmd_parser_if.slave bus
);

  localparam int unsigned NumNib = cmd_width / 4;
  localparam int unsigned CntW   = $clog2(NumNib + 1);

  typedef enum logic [1:0] {StCollect, StDiscard, StEmit} state_e;

  state_e               state_q, state_d;
  logic [cmd_width-1:0] acc_q, acc_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [cmd_width-1:0] cmd_q, cmd_d;
  logic                 err_q, err_d;
  logic                 overrun_q, overrun_d;

  // Byte classification
  logic       is_hex, is_term, is_space;
  logic [3:0] nib;

  always_comb begin
    is_hex   = 1'b0;
    nib      = 4'h0;
    is_term  = (bus.i_rx_data == 8'h0D) || (bus.i_rx_data == 8'h0A);
    is_space = (bus.i_rx_data == 8'h20);
    if (bus.i_rx_data >= 8'h30 && bus.i_rx_data <= 8'h39) begin
      is_hex = 1'b1;
      nib    = bus.i_rx_data[3:0];
    end else if ((bus.i_rx_data >= 8'h41 && bus.i_rx_data <= 8'h46) ||
                 (bus.i_rx_data >= 8'h61 && bus.i_rx_data <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so adding 9 gives the values 10..15
      is_hex = 1'b1;
      nib    = bus.i_rx_data[3:0] + 4'd9;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    err_d     = 1'b0;
    overrun_d = 1'b0;
    unique case (state_q)
      StCollect: begin
        if (bus.i_rx_valid) begin
          if (is_hex) begin
            if (cnt_q == CntW'(NumNib)) begin
              err_d   = 1'b1;
              state_d = StDiscard;
            end else begin
              // Shift the new digit in; the cast drops the top nibble
              acc_d = cmd_width'({acc_q, nib});
              cnt_d = cnt_q + CntW'(1);
            end
          end else if (is_term) begin
            // An empty line is ignored, so CR LF yields a single command
            if (cnt_q != '0) begin
              cmd_d   = acc_q;
              state_d = StEmit;
            end
          end else if (!is_space) begin
            err_d   = 1'b1;
            state_d = StDiscard;
          end
        end
      end
      StDiscard: begin
        if (bus.i_rx_valid && is_term) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StCollect;
        end
      end
      StEmit: begin
        // A byte is dropped even on the cycle the word is accepted
        overrun_d = bus.i_rx_valid;
        if (bus.i_cmd_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StCollect;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StCollect;
      acc_q     <= '0;
      cnt_q     <= '0;
      cmd_q     <= '0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.o_cmd       = cmd_q;
  assign bus.o_cmd_valid = (state_q == StEmit);
  assign bus.o_err       = err_q;
  assign bus.o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
module tb_uart_cmd_parser;
  localparam int unsigned W      = 8;
  localparam int unsigned NumNib = W / 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_cmd_parser_if #(.cmd_width(W)) bus ();

  uart_cmd_parser #(.cmd_width(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks a line as a list of digit values plus a "bad line"
  // flag and a pending word, and derives the outputs expected after each edge.
  int unsigned nibq[$];
  bit          m_bad, m_pend, m_seen_rst;
  int unsigned m_last;
  bit          e_err, e_ovr;
  int unsigned m_got[$];
  int          m_err_cnt, m_ovr_cnt;

  function automatic int hexval(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - int'("0");
    if (b >= "a" && b <= "f") return int'(b) - int'("a") + 10;
    if (b >= "A" && b <= "F") return int'(b) - int'("A") + 10;
    return -1;
  endfunction

  always @(posedge clk) begin
    e_err = 1'b0;
    e_ovr = 1'b0;
    if (rst) begin
      m_seen_rst = 1'b1;
      nibq.delete();
      m_bad  = 1'b0;
      m_pend = 1'b0;
      m_last = 0;
    end else if (m_pend) begin
      if (bus.i_rx_valid) begin
        e_ovr = 1'b1;
        m_ovr_cnt++;
      end
      if (bus.i_cmd_ready) begin
        m_got.push_back(m_last);
        m_pend = 1'b0;
      end
    end else if (bus.i_rx_valid) begin
      logic [7:0] b;
      b = bus.i_rx_data;
      if (b == 8'h0D || b == 8'h0A) begin
        if (m_bad) begin
          m_bad = 1'b0;
        end else if (nibq.size() > 0) begin
          int unsigned v;
          v = 0;
          foreach (nibq[i]) v = v * 16 + nibq[i];
          m_last = v % (1 << W);
          m_pend = 1'b1;
        end
        nibq.delete();
      end else if (b == 8'h20) begin
        // spaces never matter
      end else if (hexval(b) >= 0) begin
        if (!m_bad) begin
          if (nibq.size() == NumNib) begin
            e_err = 1'b1;
            m_bad = 1'b1;
            m_err_cnt++;
          end else begin
            nibq.push_back(hexval(b));
          end
        end
      end else if (!m_bad) begin
        e_err = 1'b1;
        m_bad = 1'b1;
        m_err_cnt++;
      end
    end
  end

  // DUT-side log of accepted words and pulses, checked against literals
  int unsigned got[$];
  int          err_cnt, ovr_cnt, vld_cyc;
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.o_cmd_valid && bus.i_cmd_ready) got.push_back(int'(bus.o_cmd));
      if (bus.o_err) err_cnt++;
      if (bus.o_overrun) ovr_cnt++;
      if (bus.o_cmd_valid) vld_cyc++;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (m_seen_rst) begin
      chk("cyc_valid", bus.o_cmd_valid, m_pend);
      chk("cyc_err", bus.o_err, e_err);
      chk("cyc_overrun", bus.o_overrun, e_ovr);
      chk("cyc_cmd", bus.o_cmd, m_last);
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d);
    bus.i_rx_valid = v;
    bus.i_rx_data  = d;
    @(posedge clk);
    #1;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;
  endtask

  task automatic line(input string s);
    for (int i = 0; i < s.len(); i++) cyc(1'b1, s[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
  endtask

  task automatic clear_logs();
    got.delete();
    m_got.delete();
    err_cnt   = 0;
    ovr_cnt   = 0;
    vld_cyc   = 0;
    m_err_cnt = 0;
    m_ovr_cnt = 0;
  endtask

  task automatic expect_cmds(input string name, input int n, input int unsigned e0,
                             input int unsigned e1, input int ne, input int no);
    chk({name, "_ncmd"}, got.size(), n);
    chk({name, "_model_ncmd"}, m_got.size(), n);
    if (n > 0 && got.size() > 0) chk({name, "_cmd0"}, got[0], e0);
    if (n > 0 && m_got.size() > 0) chk({name, "_model_cmd0"}, m_got[0], e0);
    if (n > 1 && got.size() > 1) chk({name, "_cmd1"}, got[1], e1);
    if (n > 1 && m_got.size() > 1) chk({name, "_model_cmd1"}, m_got[1], e1);
    chk({name, "_err"}, err_cnt, ne);
    chk({name, "_model_err"}, m_err_cnt, ne);
    chk({name, "_ovr"}, ovr_cnt, no);
    chk({name, "_model_ovr"}, m_ovr_cnt, no);
  endtask

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  logic [7:0] hexchars [22];

  initial begin
    hexchars = '{"0", "1", "2", "3", "4", "5", "6", "7", "8", "9", "a", "b", "c", "d",
                 "e", "f", "A", "B", "C", "D", "E", "F"};
    rst             = 1'b1;
    bus.i_rx_valid  = 1'b0;
    bus.i_rx_data   = 8'h00;
    bus.i_cmd_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_cmd", bus.o_cmd, 0);
    chk("reset_valid", bus.o_cmd_valid, 0);
    chk("reset_err", bus.o_err, 0);
    chk("reset_overrun", bus.o_overrun, 0);

    // "3c" CR, consumer always ready
    clear_logs();
    bus.i_cmd_ready = 1'b1;
    line("3c");
    cyc(1'b1, CR);
    chk("t1_valid_after_cr", bus.o_cmd_valid, 1);
    chk("t1_cmd_after_cr", bus.o_cmd, 'h3C);
    idle(3);
    expect_cmds("t1", 1, 'h3C, 0, 0, 0);
    chk("t1_valid_cycles", vld_cyc, 1);

    // A CR (gap) LF 7 LF: the LF after CR adds no command
    clear_logs();
    line("A");
    cyc(1'b1, CR);
    idle(1);
    cyc(1'b1, LF);
    line("7");
    cyc(1'b1, LF);
    idle(3);
    expect_cmds("t2", 2, 'h0A, 'h07, 0, 0);

    // Too many digits, then FF
    clear_logs();
    line("123");
    chk("t3_err_pulse", bus.o_err, 1);
    cyc(1'b1, CR);
    line("FF");
    cyc(1'b1, CR);
    idle(3);
    expect_cmds("t3", 1, 'hFF, 0, 1, 0);

    // Illegal character, then 9
    clear_logs();
    line("4G");
    chk("t4_err_pulse", bus.o_err, 1);
    line("5");
    cyc(1'b1, CR);
    line("9");
    cyc(1'b1, CR);
    idle(3);
    expect_cmds("t4", 1, 'h09, 0, 1, 0);

    // Stalled consumer with a byte arriving during the stall
    clear_logs();
    bus.i_cmd_ready = 1'b0;
    line("8");
    cyc(1'b1, CR);
    idle(3);
    line("1");
    chk("t5_overrun_pulse", bus.o_overrun, 1);
    idle(5);
    chk("t5_held_cmd", bus.o_cmd, 'h08);
    chk("t5_held_valid", bus.o_cmd_valid, 1);
    bus.i_cmd_ready = 1'b1;
    idle(1);
    line("2");
    cyc(1'b1, CR);
    idle(3);
    expect_cmds("t5", 2, 'h08, 'h02, 0, 1);

    // Reset while a command is pending
    clear_logs();
    bus.i_cmd_ready = 1'b0;
    line("55");
    cyc(1'b1, CR);
    idle(2);
    chk("t6_pending_cmd", bus.o_cmd, 'h55);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("t6_rst_valid", bus.o_cmd_valid, 0);
    chk("t6_rst_cmd", bus.o_cmd, 0);
    bus.i_cmd_ready = 1'b1;
    line("6");
    cyc(1'b1, CR);
    idle(3);
    expect_cmds("t6", 1, 'h06, 0, 0, 0);

    // Randomized traffic, checked every cycle by the model
    for (int n = 0; n < 4000; n++) begin
      int unsigned r;
      logic [7:0]  b;
      r = $urandom_range(0, 15);
      if (r < 8) b = hexchars[$urandom_range(0, 21)];
      else if (r == 8) b = CR;
      else if (r == 9) b = LF;
      else if (r == 10) b = 8'h20;
      else b = 8'($urandom_range(0, 255));
      bus.i_cmd_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 499) == 0);
      cyc(($urandom_range(0, 1) == 1), b);
    end
    rst = 1'b0;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
